// File: rtl/cpu19_pkg.sv
// Shared types and sizes for the 19-bit pipeline: register file, pipeline registers, hazard unit.
package cpu19_pkg;

    localparam int unsigned XLEN   = 19;
    localparam int unsigned REG_AW = 3;
    localparam int unsigned NREGS  = 8;

    typedef logic [XLEN-1:0]   word_t;
    typedef logic [REG_AW-1:0] regaddr_t;

    // Writeback source select: load data or ALU result, full width.
    function automatic word_t wb_select(logic memtoreg, word_t rdata, word_t alu);
        return memtoreg ? rdata : alu;
    endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB writeback bus, ID read ports and debug trace of the writeback register file.
interface wb_regfile_if #(
    parameter int unsigned CNT_W = 16
) ();
    import cpu19_pkg::*;

    logic             WB_regwrite;
    logic             WB_memtoreg;
    word_t            WB_rdata;
    word_t            WB_out;
    regaddr_t         WB_rd;
    regaddr_t         rs1_addr;
    regaddr_t         rs2_addr;
    word_t            rs1_data;
    word_t            rs2_data;
    logic             trc_valid;
    regaddr_t         trc_rd;
    word_t            trc_data;
    logic [CNT_W-1:0] retire_cnt;

    modport master (
        output WB_regwrite, WB_memtoreg, WB_rdata, WB_out, WB_rd, rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, trc_valid, trc_rd, trc_data, retire_cnt
    );

    modport slave (
        input  WB_regwrite, WB_memtoreg, WB_rdata, WB_out, WB_rd, rs1_addr, rs2_addr,
        output rs1_data, rs2_data, trc_valid, trc_rd, trc_data, retire_cnt
    );

endinterface

// File: rtl/regfile_core.sv
// 8x19 register array: one synchronous write port, two combinational read ports, async clear.
module regfile_core
    import cpu19_pkg::*;
#(
    parameter bit R0_ZERO = 1'b1
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     we,
    input  regaddr_t waddr,
    input  word_t    wdata,
    input  regaddr_t raddr1,
    input  regaddr_t raddr2,
    output word_t    rdata1,
    output word_t    rdata2
);

    word_t regs_q [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[waddr] <= wdata;
        end
    end

    // Address 0 is hard-wired to zero on the read side as well, independent of array contents.
    always_comb begin
        rdata1 = regs_q[raddr1];
        rdata2 = regs_q[raddr2];
        if (R0_ZERO && (raddr1 == '0)) rdata1 = '0;
        if (R0_ZERO && (raddr2 == '0)) rdata2 = '0;
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: source mux, commit, register file, debug trace and retire counter.
// Define WB_BYPASS_EN to forward the committing value to same-cycle reads of WB_rd.
module wb_regfile
    import cpu19_pkg::*;
#(
    parameter int unsigned R0_ZERO = 1,
    parameter int unsigned CNT_W   = 16
) (
    input logic         clk,
    input logic         rst_n,
    wb_regfile_if.slave bus
);

    word_t            wb_val;
    logic             commit;
    word_t            core_rd1;
    word_t            core_rd2;
    logic             trc_valid_q;
    regaddr_t         trc_rd_q;
    word_t            trc_data_q;
    logic [CNT_W-1:0] retire_cnt_q;

    always_comb begin
        wb_val = wb_select(bus.WB_memtoreg, bus.WB_rdata, bus.WB_out);
        commit = bus.WB_regwrite && !((R0_ZERO != 0) && (bus.WB_rd == '0));
    end

    regfile_core #(
        .R0_ZERO (R0_ZERO != 0)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (commit),
        .waddr  (bus.WB_rd),
        .wdata  (wb_val),
        .raddr1 (bus.rs1_addr),
        .raddr2 (bus.rs2_addr),
        .rdata1 (core_rd1),
        .rdata2 (core_rd2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trc_valid_q  <= 1'b0;
            trc_rd_q     <= '0;
            trc_data_q   <= '0;
            retire_cnt_q <= '0;
        end else begin
            trc_valid_q <= commit;
            if (commit) begin
                trc_rd_q     <= bus.WB_rd;
                trc_data_q   <= wb_val;
                retire_cnt_q <= retire_cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
`ifdef WB_BYPASS_EN
        // commit is already false for R0 when it is hard-wired, so no bypass of zero writes.
        bus.rs1_data = (commit && (bus.rs1_addr == bus.WB_rd)) ? wb_val : core_rd1;
        bus.rs2_data = (commit && (bus.rs2_addr == bus.WB_rd)) ? wb_val : core_rd2;
`else
        bus.rs1_data = core_rd1;
        bus.rs2_data = core_rd2;
`endif
        bus.trc_valid  = trc_valid_q;
        bus.trc_rd     = trc_rd_q;
        bus.trc_data   = trc_data_q;
        bus.retire_cnt = retire_cnt_q;
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed table, random run against an array model,
// reset-in-flight, same-cycle read/write, counter wrap and R0 as an ordinary register.
module tb_wb_regfile;
    import cpu19_pkg::*;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    wb_regfile_if #(.CNT_W(16)) bus ();
    wb_regfile_if #(.CNT_W(4))  busw ();

    wb_regfile #(.R0_ZERO(1), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    wb_regfile #(.R0_ZERO(0), .CNT_W(4)) dut_w (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state for the R0_ZERO=1, CNT_W=16 instance.
    logic [18:0] m_reg [8];
    logic        m_tv;
    logic [2:0]  m_trd;
    logic [18:0] m_tdata;
    int unsigned m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        m_tv = 0; m_trd = '0; m_tdata = '0; m_cnt = 0;
    endtask

    function automatic logic [18:0] model_read(input logic [2:0] a, input logic rw,
                                               input logic [2:0] rd, input logic [18:0] v);
        logic [18:0] r;
        r = (a == 0) ? 19'h0 : m_reg[a];
`ifdef WB_BYPASS_EN
        if (rw && rd != 0 && a == rd) r = v;
`endif
        return r;
    endfunction

    task automatic model_edge(input logic rw, input logic [2:0] rd, input logic [18:0] v);
        if (rw && rd != 0) begin
            m_reg[rd] = v; m_tv = 1; m_trd = rd; m_tdata = v;
            m_cnt = (m_cnt + 1) % 65536;
        end else begin
            m_tv = 0;
        end
    endtask

    task automatic drive(input logic rw, input logic mr, input logic [18:0] rdata,
                         input logic [18:0] out, input logic [2:0] rd,
                         input logic [2:0] a1, input logic [2:0] a2);
        bus.WB_regwrite = rw; bus.WB_memtoreg = mr; bus.WB_rdata = rdata;
        bus.WB_out = out; bus.WB_rd = rd; bus.rs1_addr = a1; bus.rs2_addr = a2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rw;
        logic        mr;
        logic [18:0] rdata;
        logic [18:0] out;
        logic [2:0]  rd;
        logic [2:0]  a1;
        logic [2:0]  a2;
        logic [18:0] e_rs1;
        logic [18:0] e_rs2;
        logic        e_tv;
        logic [2:0]  e_trd;
        logic [18:0] e_tdata;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic        rw, mr;
        logic [18:0] rdata, out, v;
        logic [2:0]  rd, a1, a2;

        n_pass = 0; n_total = 0;
        vecs[0] = '{1, 1, 19'h1A5A5, 19'h15A5A, 3'd5, 3'd5, 3'd0,
                    19'h1A5A5, 19'h0, 1, 3'd5, 19'h1A5A5, 16'd1};
        vecs[1] = '{1, 0, 19'h00000, 19'h15A5A, 3'd2, 3'd2, 3'd5,
                    19'h15A5A, 19'h1A5A5, 1, 3'd2, 19'h15A5A, 16'd2};
        vecs[2] = '{0, 1, 19'h7FFFF, 19'h00000, 3'd2, 3'd2, 3'd2,
                    19'h15A5A, 19'h15A5A, 0, 3'd2, 19'h15A5A, 16'd2};
        vecs[3] = '{1, 0, 19'h00000, 19'h7FFFF, 3'd0, 3'd0, 3'd0,
                    19'h0, 19'h0, 0, 3'd2, 19'h15A5A, 16'd2};
        vecs[4] = '{1, 0, 19'h00000, 19'h00007, 3'd3, 3'd3, 3'd2,
                    19'h00007, 19'h15A5A, 1, 3'd3, 19'h00007, 16'd3};

        rst_n = 0;
        drive(0, 0, '0, '0, '0, '0, '0);
        busw.WB_regwrite = 0; busw.WB_memtoreg = 0; busw.WB_rdata = '0; busw.WB_out = '0;
        busw.WB_rd = '0; busw.rs1_addr = '0; busw.rs2_addr = '0;
        model_reset();
        #12;
        check("reset_trc_valid", 32'(bus.trc_valid), 0);
        check("reset_cnt", 32'(bus.retire_cnt), 0);
        check("reset_rs1", 32'(bus.rs1_data), 0);
        @(negedge clk);
        rst_n = 1;
        tick();

        // Directed table
        foreach (vecs[i]) begin
            drive(vecs[i].rw, vecs[i].mr, vecs[i].rdata, vecs[i].out, vecs[i].rd,
                  vecs[i].a1, vecs[i].a2);
            tick();
            check($sformatf("vec%0d_rs1", i), 32'(bus.rs1_data), 32'(vecs[i].e_rs1));
            check($sformatf("vec%0d_rs2", i), 32'(bus.rs2_data), 32'(vecs[i].e_rs2));
            check($sformatf("vec%0d_tv", i), 32'(bus.trc_valid), 32'(vecs[i].e_tv));
            check($sformatf("vec%0d_trd", i), 32'(bus.trc_rd), 32'(vecs[i].e_trd));
            check($sformatf("vec%0d_tdata", i), 32'(bus.trc_data), 32'(vecs[i].e_tdata));
            check($sformatf("vec%0d_cnt", i), 32'(bus.retire_cnt), 32'(vecs[i].e_cnt));
            model_edge(vecs[i].rw, vecs[i].rd,
                       vecs[i].mr ? vecs[i].rdata : vecs[i].out);
        end

        // Same-cycle read/write of reg3 (holds 7)
        drive(1, 0, 19'h7FFFF, 19'h00123, 3'd3, 3'd3, 3'd3);
        #1;
`ifdef WB_BYPASS_EN
        check("rw_same_pre", 32'(bus.rs1_data), 32'h00123);
`else
        check("rw_same_pre", 32'(bus.rs1_data), 32'h00007);
`endif
        tick();
        model_edge(1, 3'd3, 19'h00123);
        check("rw_same_post1", 32'(bus.rs1_data), 32'h00123);
        check("rw_same_post2", 32'(bus.rs2_data), 32'h00123);
        check("rw_same_cnt", 32'(bus.retire_cnt), 4);

        // Random run against the model
        for (int n = 0; n < 150; n++) begin
            rw = 1'($urandom_range(0, 1)); mr = 1'($urandom_range(0, 1));
            rdata = 19'($urandom); out = 19'($urandom); rd = 3'($urandom);
            a1 = 3'($urandom); a2 = (n % 4 == 0) ? rd : 3'($urandom);
            v = mr ? rdata : out;
            drive(rw, mr, rdata, out, rd, a1, a2);
            #1;
            check("rnd_rs1", 32'(bus.rs1_data), 32'(model_read(a1, rw, rd, v)));
            check("rnd_rs2", 32'(bus.rs2_data), 32'(model_read(a2, rw, rd, v)));
            tick();
            model_edge(rw, rd, v);
            check("rnd_tv", 32'(bus.trc_valid), 32'(m_tv));
            check("rnd_trd", 32'(bus.trc_rd), 32'(m_trd));
            check("rnd_tdata", 32'(bus.trc_data), 32'(m_tdata));
            check("rnd_cnt", 32'(bus.retire_cnt), m_cnt);
        end

        // Reset mid-cycle with a write pending: immediate clear, write lost
        drive(1, 0, 19'h0, 19'h2AAAA, 3'd6, 3'd6, 3'd6);
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check("rst_tv", 32'(bus.trc_valid), 0);
        check("rst_cnt", 32'(bus.retire_cnt), 0);
        for (int i = 0; i < 8; i++) begin
            bus.rs1_addr = 3'(i);
            #1;
            check($sformatf("rst_reg%0d", i), 32'(bus.rs1_data), 0);
        end
        bus.rs1_addr = 3'd6;
        tick();
        check("rst_write_lost", 32'(bus.rs1_data), 0);
        check("rst_write_uncnt", 32'(bus.retire_cnt), 0);
        #2;
        rst_n = 1;
        drive(0, 0, '0, '0, '0, 3'd6, 3'd6);
        tick();
        check("rst_release_reg6", 32'(bus.rs1_data), 0);
        check("rst_release_cnt", 32'(bus.retire_cnt), 0);

        // Counter wrap on CNT_W=4 instance: 17 commits -> 1
        for (int i = 1; i <= 17; i++) begin
            busw.WB_regwrite = 1; busw.WB_memtoreg = 0;
            busw.WB_out = 19'(i * 19'h00101); busw.WB_rd = 3'd1; busw.rs1_addr = 3'd1;
            tick();
        end
        busw.WB_regwrite = 0;
        #1;
        check("wrap_cnt", 32'(busw.retire_cnt), 1);
        check("wrap_reg1", 32'(busw.rs1_data), 32'(19'(17 * 19'h00101)));

        // R0 ordinary register when R0_ZERO=0
        busw.WB_regwrite = 1; busw.WB_out = 19'h55555; busw.WB_rd = 3'd0;
        busw.rs2_addr = 3'd0;
        tick();
        busw.WB_regwrite = 0;
        #1;
        check("r0_plain_read", 32'(busw.rs2_data), 32'h55555);
        check("r0_plain_tv", 32'(busw.trc_valid), 1);
        check("r0_plain_cnt", 32'(busw.retire_cnt), 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-stage consumer of the MEM/WB pipeline register outputs.
- Selects the writeback value (load data or ALU result) and commits it to an 8-entry x 19-bit architectural register file.
- Serves the two ID-stage read ports.
- Keeps a registered writeback trace and a retire counter for debug and bench checking.

Parameters:
- XLEN, 19, data width.
- NREGS, 8, register count; address width is 3.
- R0_ZERO, 1, when 1 register 0 reads as zero and writes to it are discarded.
- CNT_W, 16, width of the retire counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- WB_regwrite  in  1  writeback enable from MEM/WB.
- WB_memtoreg  in  1  1 selects WB_rdata, 0 selects WB_out.
- WB_rdata  in  XLEN  load data from MEM/WB.
- WB_out  in  XLEN  ALU result from MEM/WB.
- WB_rd  in  3  destination register.
- rs1_addr  in  3  ID read port 1 address.
- rs2_addr  in  3  ID read port 2 address.
- rs1_data  out  XLEN  read port 1 data, combinational.
- rs2_data  out  XLEN  read port 2 data, combinational.
- trc_valid  out  1  registered: a commit occurred last cycle.
- trc_rd  out  3  registered: destination of that commit.
- trc_data  out  XLEN  registered: value committed.
- retire_cnt  out  CNT_W  count of committed writes.

Behaviour:
- Reset (async assert, sync release on the next clk edge): all 8 registers become 0. trc_valid, trc_rd, trc_data and retire_cnt become 0. rs1_data and rs2_data therefore read 0.
- Writeback value: wb_val = WB_memtoreg ? WB_rdata : WB_out. Full XLEN width, no extension or truncation.
- Commit condition: commit = WB_regwrite && !(R0_ZERO && WB_rd==0).
- On a clk rising edge with commit: reg[WB_rd] <= wb_val; trc_valid<=1, trc_rd<=WB_rd, trc_data<=wb_val; retire_cnt increments by 1, wrapping modulo 2^CNT_W with no saturation. Write latency: visible in the array one edge after the inputs are presented.
- On an edge without commit: trc_valid<=0; trc_rd and trc_data hold; array and counter unchanged.
- Write to R0 with R0_ZERO=1 is not a commit:
  - trc_valid stays 0.
  - retire_cnt is unchanged.
  - reads of address 0 always return 0.
- With R0_ZERO=0, R0 behaves as an ordinary register.
- WB_regwrite=0: WB_memtoreg, WB_rdata, WB_out and WB_rd are don't-care and have no effect.
- Reads: rs*_data = reg[rs*_addr], combinational. Both ports may address the same register; both return the same value.
- Simultaneous read and write to the same register: covered by the optional feature.
- Reset asserted mid-operation: takes effect immediately and overrides any write on that edge. A write presented during reset is lost and is not counted.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: when commit is true and rs*_addr==WB_rd in the same cycle, rs*_data returns wb_val (write-through). This closes the WB-to-ID hazard, so ID needs no extra stall. R0 rule still applies.
- Not defined: the read returns the pre-write array value. The new value is visible from the next cycle, and the hazard unit must stall or forward.

Decomposition:
- Shared package cpu19_pkg: XLEN=19, REG_AW=3, NREGS=8, typedef word_t [18:0], typedef regaddr_t [2:0].
- The MEM/WB register, EX/MEM register and hazard unit use the same package.
- One natural sub-module, regfile_core: 8x19 array, one write port, two combinational read ports, reset clear.
- wb_regfile adds the writeback mux, commit logic, bypass, trace and counter.

Test Plan:
- Reset: drive rst_n=0 mid-run after several writes -> all rs reads 0, trc_valid=0, retire_cnt=0 immediately, before any clk edge.
- Load writeback: regwrite=1, memtoreg=1, rdata=19'h1A5A5, out=19'h15A5A, rd=5 -> after edge: rs1_addr=5 reads 19'h1A5A5; trc_valid=1, trc_rd=5, trc_data=19'h1A5A5; retire_cnt=1.
- ALU writeback then idle: regwrite=1, memtoreg=0, out=19'h15A5A, rd=2, then regwrite=0 with rdata=19'h7FFFF, rd=2 -> reg2 stays 19'h15A5A; trc_valid drops to 0 on the idle edge; retire_cnt=2.
- R0: regwrite=1, rd=0, out=19'h7FFFF -> rs2_addr=0 reads 0; trc_valid=0; retire_cnt unchanged.
- Same-cycle read/write: rd=3, out=19'h00123 with rs1_addr=3; reg3 previously 19'h00007 -> with WB_BYPASS_EN rs1_data=19'h00123 before the edge; without it, rs1_data=19'h00007 before the edge and 19'h00123 after.
- Counter wrap: CNT_W=4, 17 consecutive commits to rd=1 -> retire_cnt=1; reg1 holds the last value.
